coef_loader: RTL and testbench

COEF_LOADER -- requirements
Module: coef_loader

---
 rtl/coef_loader_if.sv | 11 +
 rtl/coef_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_coef_loader.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coef_loader_if.sv
// Word-stream handshake between a coefficient source and the loader.
// The master drives valid/data/last, and the slave answers with ready.
interface coef_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_data;
    logic       in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/coef_loader.sv
// Receives 24-word coefficient frames into a shadow set and range-checks each pair.
// Commits the set atomically to the root solver's inputs, or rejects the frame with a cause code.
module coef_loader #(
    parameter int TIMEOUT = 1024,
    parameter int NPAIR   = 12
) (
    input  logic         clk,
    input  logic         reset,
    coef_loader_if.slave src,
    output logic [1:0]   z01,
    output logic [1:0]   z02,
    output logic [1:0]   z03,
    output logic [1:0]   z04,
    output logic [1:0]   z05,
    output logic [1:0]   z06,
    output logic [1:0]   z07,
    output logic [1:0]   z08,
    output logic [1:0]   z09,
    output logic [1:0]   z010,
    output logic [1:0]   z011,
    output logic [1:0]   z012,
    output logic [1:0]   z11,
    output logic [1:0]   z12,
    output logic [1:0]   z13,
    output logic [1:0]   z14,
    output logic [1:0]   z15,
    output logic [1:0]   z16,
    output logic [1:0]   z17,
    output logic [1:0]   z18,
    output logic [1:0]   z19,
    output logic [1:0]   z110,
    output logic [1:0]   z111,
    output logic [1:0]   z112,
    output logic         coef_valid,
    output logic         solver_restart,
    output logic         frame_err,
    output logic [1:0]   err_code
);

    localparam int NWORD = 2 * NPAIR;
    localparam int WCW   = $clog2(NWORD + 1);
    localparam int ICW   = $clog2(TIMEOUT + 1);
    localparam int PCW   = (NPAIR > 1) ? $clog2(NPAIR) : 1;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_RANGE   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WCW-1:0]   word_cnt_reg;
    logic [ICW-1:0]   idle_cnt_reg;
    logic [PCW-1:0]   pair_reg;
    logic [1:0]       shadow0_reg [NPAIR];
    logic [1:0]       shadow1_reg [NPAIR];
    logic [1:0]       act0_reg    [NPAIR];
    logic [1:0]       act1_reg    [NPAIR];
    logic             coef_valid_reg;
    logic             restart_reg;
    logic             frame_err_reg;
    logic [1:0]       err_code_reg;

    logic             in_ready_c;
    logic             reject_c;
    logic             commit_c;
    logic [1:0]       reject_code_c;

    logic             accept;
    logic [WCW-1:0]   cur_idx;
    logic             at_last_slot;
    logic             len_bad;
    logic             frame_done;
    logic             timeout_hit;
    logic [2:0]       pair_diff;
    logic             range_bad;
    logic             pair_last;
    logic [NPAIR-1:0] we0;
    logic [NPAIR-1:0] we1;

    // In IDLE the incoming word is always word 0, whatever the stale count holds.
    assign accept       = src.in_valid & in_ready_c;
    assign cur_idx      = (state_reg == ST_LOAD) ? word_cnt_reg : '0;
    assign at_last_slot = (cur_idx == WCW'(NWORD - 1));
    assign len_bad      = accept & (src.in_last ^ at_last_slot);
    assign frame_done   = accept & src.in_last & at_last_slot;
    assign timeout_hit  = (state_reg == ST_LOAD) & ~accept
                        & (idle_cnt_reg == ICW'(TIMEOUT - 1));

    // Differences of +/-3 alias in the solver's decoder, so they are refused here.
    assign pair_diff = {shadow1_reg[pair_reg][1], shadow1_reg[pair_reg]}
                     - {shadow0_reg[pair_reg][1], shadow0_reg[pair_reg]};
    assign range_bad = (state_reg == ST_CHECK)
                     & ((pair_diff == 3'b011) | (pair_diff == 3'b101));
    assign pair_last = (pair_reg == PCW'(NPAIR - 1));

    genvar gi;
    generate
        for (gi = 0; gi < NPAIR; gi++) begin : g_we
            assign we0[gi] = accept & (cur_idx == WCW'(gi));
            assign we1[gi] = accept & (cur_idx == WCW'(gi + NPAIR));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = len_bad ? ST_IDLE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (len_bad || timeout_hit) begin
                    state_next = ST_IDLE;
                end else if (frame_done) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (range_bad) begin
                    state_next = ST_IDLE;
                end else if (pair_last) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_c    = (state_reg == ST_IDLE) || (state_reg == ST_LOAD);
        commit_c      = (state_reg == ST_COMMIT);
        reject_c      = len_bad | timeout_hit | range_bad;
        reject_code_c = ERR_NONE;
        if (len_bad) begin
            reject_code_c = ERR_LEN;
        end else if (timeout_hit) begin
            reject_code_c = ERR_TIMEOUT;
        end else if (range_bad) begin
            reject_code_c = ERR_RANGE;
        end
    end

    assign src.in_ready = in_ready_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt_reg   <= '0;
            idle_cnt_reg   <= '0;
            pair_reg       <= '0;
            coef_valid_reg <= 1'b0;
            restart_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
            err_code_reg   <= ERR_NONE;
            for (int k = 0; k < NPAIR; k++) begin
                shadow0_reg[k] <= '0;
                shadow1_reg[k] <= '0;
                act0_reg[k]    <= '0;
                act1_reg[k]    <= '0;
            end
        end else begin
            restart_reg   <= commit_c;
            frame_err_reg <= reject_c;
            if (accept) begin
                word_cnt_reg <= cur_idx + WCW'(1);
            end
            if ((state_reg == ST_LOAD) && !accept && !timeout_hit) begin
                idle_cnt_reg <= idle_cnt_reg + ICW'(1);
            end else begin
                idle_cnt_reg <= '0;
            end
            // Index restarts at 0 on any way out of CHECK, including a range reject.
            if ((state_reg == ST_CHECK) && (state_next == ST_CHECK)) begin
                pair_reg <= pair_reg + PCW'(1);
            end else begin
                pair_reg <= '0;
            end
            for (int k = 0; k < NPAIR; k++) begin
                if (we0[k]) shadow0_reg[k] <= src.in_data;
                if (we1[k]) shadow1_reg[k] <= src.in_data;
            end
            if (reject_c) begin
                err_code_reg <= reject_code_c;
            end
            if (commit_c) begin
                for (int k = 0; k < NPAIR; k++) begin
                    act0_reg[k] <= shadow0_reg[k];
                    act1_reg[k] <= shadow1_reg[k];
                end
                coef_valid_reg <= 1'b1;
                err_code_reg   <= ERR_NONE;
            end
        end
    end

    assign coef_valid     = coef_valid_reg;
    assign solver_restart = restart_reg;
    assign frame_err      = frame_err_reg;
    assign err_code       = err_code_reg;

    assign z01  = act0_reg[0];
    assign z02  = act0_reg[1];
    assign z03  = act0_reg[2];
    assign z04  = act0_reg[3];
    assign z05  = act0_reg[4];
    assign z06  = act0_reg[5];
    assign z07  = act0_reg[6];
    assign z08  = act0_reg[7];
    assign z09  = act0_reg[8];
    assign z010 = act0_reg[9];
    assign z011 = act0_reg[10];
    assign z012 = act0_reg[11];
    assign z11  = act1_reg[0];
    assign z12  = act1_reg[1];
    assign z13  = act1_reg[2];
    assign z14  = act1_reg[3];
    assign z15  = act1_reg[4];
    assign z16  = act1_reg[5];
    assign z17  = act1_reg[6];
    assign z18  = act1_reg[7];
    assign z19  = act1_reg[8];
    assign z110 = act1_reg[9];
    assign z111 = act1_reg[10];
    assign z112 = act1_reg[11];

endmodule

// File: tb/tb_coef_loader.sv
// Directed plus randomized frames for coef_loader, checked against a pair-difference model.
// The model tracks the committed coefficients, the commit flag and the rejection cause.
module tb_coef_loader;
    localparam int NP = 12;
    localparam int NW = 24;
    localparam int TO = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    coef_loader_if bus ();

    logic [1:0] z0_obs [NP];
    logic [1:0] z1_obs [NP];
    logic       coef_valid;
    logic       solver_restart;
    logic       frame_err;
    logic [1:0] err_code;

    coef_loader #(.TIMEOUT(TO), .NPAIR(NP)) dut (
        .clk(clk), .reset(reset), .src(bus),
        .z01(z0_obs[0]), .z02(z0_obs[1]), .z03(z0_obs[2]), .z04(z0_obs[3]),
        .z05(z0_obs[4]), .z06(z0_obs[5]), .z07(z0_obs[6]), .z08(z0_obs[7]),
        .z09(z0_obs[8]), .z010(z0_obs[9]), .z011(z0_obs[10]), .z012(z0_obs[11]),
        .z11(z1_obs[0]), .z12(z1_obs[1]), .z13(z1_obs[2]), .z14(z1_obs[3]),
        .z15(z1_obs[4]), .z16(z1_obs[5]), .z17(z1_obs[6]), .z18(z1_obs[7]),
        .z19(z1_obs[8]), .z110(z1_obs[9]), .z111(z1_obs[10]), .z112(z1_obs[11]),
        .coef_valid(coef_valid), .solver_restart(solver_restart),
        .frame_err(frame_err), .err_code(err_code)
    );

    logic [1:0] m_z0 [NP];
    logic [1:0] m_z1 [NP];
    logic       m_valid;
    logic [1:0] m_err;
    logic [1:0] fr [NW];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input logic [1:0] v);
        return v[1] ? int'(v) - 4 : int'(v);
    endfunction

    function automatic int first_bad();
        for (int k = 0; k < NP; k++) begin
            int d;
            d = sx(fr[NP + k]) - sx(fr[k]);
            if (d > 2 || d < -2) return k;
        end
        return -1;
    endfunction

    function automatic logic [47:0] obs_vec();
        logic [47:0] v;
        for (int k = 0; k < NP; k++) begin
            v[2*k +: 2]      = z0_obs[k];
            v[24 + 2*k +: 2] = z1_obs[k];
        end
        return v;
    endfunction

    function automatic logic [47:0] model_vec();
        logic [47:0] v;
        for (int k = 0; k < NP; k++) begin
            v[2*k +: 2]      = m_z0[k];
            v[24 + 2*k +: 2] = m_z1[k];
        end
        return v;
    endfunction

    task automatic commit_model();
        for (int k = 0; k < NP; k++) begin
            m_z0[k] = fr[k];
            m_z1[k] = fr[NP + k];
        end
        m_valid = 1'b1;
        m_err   = 2'b00;
    endtask

    task automatic check_active(input string tag);
        check({tag, "_z"}, obs_vec(), model_vec());
        check({tag, "_valid"}, coef_valid, m_valid);
        check({tag, "_code"}, err_code, m_err);
    endtask

    task automatic gen_frame(input int bad_k);
        for (int k = 0; k < NP; k++) begin
            logic [1:0] a;
            logic [1:0] b;
            int d;
            do begin
                a = 2'($urandom_range(0, 3));
                b = 2'($urandom_range(0, 3));
                d = sx(b) - sx(a);
            end while (d > 2 || d < -2);
            if (k == bad_k) begin
                if ($urandom_range(0, 1) == 0) begin
                    a = 2'b01; b = 2'b10;
                end else begin
                    a = 2'b10; b = 2'b01;
                end
            end
            fr[k]      = a;
            fr[NP + k] = b;
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Presents one word and returns just after the edge that accepted it.
    task automatic put_word(input logic [1:0] d, input logic last, output int stalls);
        bit done;
        logic rdy;
        done = 0;
        stalls = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!done) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                done = 1;
            end else begin
                stalls++;
                if (stalls > 100) begin
                    check("ready_wait", 64'd0, 64'd1);
                    done = 1;
                end
            end
        end
    endtask

    task automatic send_words(input int from, input int upto, input int last_at, input bit gaps);
        int st;
        for (int i = from; i <= upto; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            put_word(fr[i], (i == last_at), st);
        end
    endtask

    // Waits for the outcome of a frame whose last word was just accepted.
    task automatic observe(input string tag);
        int fb;
        int n;
        bit hit;
        fb = first_bad();
        n = 0;
        hit = 0;
        while (!hit && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (solver_restart || frame_err) hit = 1;
        end
        if (fb < 0) begin
            check({tag, "_latency"}, n, 13);
            check({tag, "_restart"}, solver_restart, 1'b1);
            check({tag, "_noerr"}, frame_err, 1'b0);
            commit_model();
            check_active(tag);
            @(posedge clk);
            #1;
            check({tag, "_restart_end"}, solver_restart, 1'b0);
        end else begin
            check({tag, "_errcycle"}, n, fb + 1);
            check({tag, "_err"}, frame_err, 1'b1);
            check({tag, "_norestart"}, solver_restart, 1'b0);
            m_err = 2'b11;
            check_active(tag);
            @(posedge clk);
            #1;
            check({tag, "_err_end"}, frame_err, 1'b0);
        end
    endtask

    initial begin
        int st;
        int c;
        bit hit;

        bus.in_valid = 1'b0;
        bus.in_data  = 2'b00;
        bus.in_last  = 1'b0;
        for (int k = 0; k < NP; k++) begin
            m_z0[k] = 2'b00;
            m_z1[k] = 2'b00;
        end
        m_valid = 1'b0;
        m_err   = 2'b00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_active("reset");
        check("reset_restart", solver_restart, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ready", bus.in_ready, 1'b1);

        // All z0k=00, z1k=01, back to back
        for (int k = 0; k < NP; k++) begin
            fr[k]      = 2'b00;
            fr[NP + k] = 2'b01;
        end
        send_words(0, NW - 1, NW - 1, 0);
        idle();
        observe("basic");

        // Early in_last on word 10
        gen_frame(-1);
        send_words(0, 10, 10, 0);
        idle();
        check("len_early_pulse", frame_err, 1'b1);
        m_err = 2'b01;
        check_active("len_early");
        @(posedge clk);
        #1;
        check("len_early_clear", frame_err, 1'b0);

        // Word 23 without in_last
        gen_frame(-1);
        send_words(0, NW - 1, -1, 0);
        idle();
        check("len_nolast_pulse", frame_err, 1'b1);
        check_active("len_nolast");

        gen_frame(-1);
        send_words(0, NW - 1, NW - 1, 0);
        idle();
        observe("after_len");

        // Timeout after 5 words
        gen_frame(-1);
        send_words(0, 4, -1, 0);
        idle();
        c = 0;
        hit = 0;
        while (!hit && c < TO + 50) begin
            @(posedge clk);
            #1;
            c++;
            if (frame_err) hit = 1;
        end
        check("timeout_cycles", c, TO);
        m_err = 2'b10;
        check_active("timeout");
        check("timeout_idle_ready", bus.in_ready, 1'b1);

        // Pair 5 with d = -3
        gen_frame(-1);
        fr[5]      = 2'b01;
        fr[NP + 5] = 2'b10;
        send_words(0, NW - 1, NW - 1, 0);
        idle();
        check("range_first_bad", first_bad(), 5);
        observe("range_k5");

        // Word held through CHECK/COMMIT becomes word 0 of the next frame
        gen_frame(-1);
        send_words(0, NW - 1, NW - 1, 0);
        commit_model();
        gen_frame(-1);
        put_word(fr[0], 1'b0, st);
        check("hold_stalls", st, 13);
        check_active("hold_prev");
        send_words(1, NW - 1, NW - 1, 0);
        idle();
        observe("hold_next");

        // Randomized frames, some with an out-of-range pair, some with gaps
        for (int f = 0; f < 8; f++) begin
            gen_frame(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NP - 1)) : -1);
            send_words(0, NW - 1, NW - 1, 1);
            idle();
            observe("random");
        end

        // Asynchronous reset after word 17
        gen_frame(-1);
        send_words(0, 17, -1, 0);
        idle();
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < NP; k++) begin
            m_z0[k] = 2'b00;
            m_z1[k] = 2'b00;
        end
        m_valid = 1'b0;
        m_err   = 2'b00;
        check_active("async_rst");
        check("async_rst_restart", solver_restart, 1'b0);
        check("async_rst_frame_err", frame_err, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", bus.in_ready, 1'b1);
        gen_frame(-1);
        send_words(0, NW - 1, NW - 1, 0);
        idle();
        observe("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
